// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - result bus bundle between ALU/LSB producers, the arbiter and the ROB
//
// Purpose: groups the ALU result port, the LSB load-data port, the shared
// completion (cdb) port and the sticky drop flag into one bundle.
// Port summary:
//   alu_valid/alu_tag/alu_op/alu_rd/alu_wdata/alu_jump -> arbiter, alu_ready <- arbiter
//   lsb_valid/lsb_tag/lsb_wdata                        -> arbiter, lsb_ready <- arbiter
//   cdb_valid/cdb_src/cdb_tag/cdb_op/cdb_rd/cdb_wdata/cdb_jump <- arbiter (to ROB)
//   err_drop                                           <- arbiter (sticky)
// Modports: master = producer/consumer side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 alu_valid;
  logic [ROB_WIDTH-1:0] alu_tag;
  logic [2:0]           alu_op;
  logic [4:0]           alu_rd;
  logic [31:0]          alu_wdata;
  logic [31:0]          alu_jump;
  logic                 alu_ready;

  logic                 lsb_valid;
  logic [ROB_WIDTH-1:0] lsb_tag;
  logic [31:0]          lsb_wdata;
  logic                 lsb_ready;

  logic                 cdb_valid;
  logic                 cdb_src;
  logic [ROB_WIDTH-1:0] cdb_tag;
  logic [2:0]           cdb_op;
  logic [4:0]           cdb_rd;
  logic [31:0]          cdb_wdata;
  logic [31:0]          cdb_jump;

  logic                 err_drop;

  modport master (
    output alu_valid, alu_tag, alu_op, alu_rd, alu_wdata, alu_jump,
    input  alu_ready,
    output lsb_valid, lsb_tag, lsb_wdata,
    input  lsb_ready,
    input  cdb_valid, cdb_src, cdb_tag, cdb_op, cdb_rd, cdb_wdata, cdb_jump,
    input  err_drop
  );

  modport slave (
    input  alu_valid, alu_tag, alu_op, alu_rd, alu_wdata, alu_jump,
    output alu_ready,
    input  lsb_valid, lsb_tag, lsb_wdata,
    output lsb_ready,
    output cdb_valid, cdb_src, cdb_tag, cdb_op, cdb_rd, cdb_wdata, cdb_jump,
    output err_drop
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin writeback arbiter sharing the ROB completion port
//
// Purpose: buffers ALU and LSB results in one 2-entry FIFO per source and
// drives one registered result per cycle onto the cdb, alternating between
// sources under contention. clear flushes every buffered result.
// Port summary:
//   clk_in  - clock
//   rst_in  - synchronous active-high reset (also clears err_drop)
//   rdy_in  - global enable; low freezes all state
//   clear   - pipeline flush; like reset except err_drop is kept
//   bus     - cdb_arbiter_if.slave: ALU/LSB inputs with ready, cdb outputs, err_drop
module cdb_arbiter #(
  parameter int ROB_WIDTH = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clear,
  cdb_arbiter_if.slave  bus
);

  localparam logic [2:0] OP_LOAD = 3'd3;

  typedef struct packed {
    logic [ROB_WIDTH-1:0] tag;
    logic [2:0]           op;
    logic [4:0]           rd;
    logic [31:0]          wdata;
    logic [31:0]          jump;
  } alu_ent_t;

  typedef struct packed {
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          wdata;
  } lsb_ent_t;

  // FIFO storage (no reset needed: occupancy is tracked by the counts)
  alu_ent_t             alu_mem_q [2];
  lsb_ent_t             lsb_mem_q [2];

  logic                 alu_wp_q, alu_wp_d, alu_rp_q, alu_rp_d;
  logic [1:0]           alu_cnt_q, alu_cnt_d;
  logic                 lsb_wp_q, lsb_wp_d, lsb_rp_q, lsb_rp_d;
  logic [1:0]           lsb_cnt_q, lsb_cnt_d;

  // 0 = ALU granted last, 1 = LSB granted last
  logic                 last_grant_q, last_grant_d;
  logic                 err_q, err_d;

  logic                 cdb_valid_q, cdb_valid_d;
  logic                 cdb_src_q, cdb_src_d;
  logic [ROB_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
  logic [2:0]           cdb_op_q, cdb_op_d;
  logic [4:0]           cdb_rd_q, cdb_rd_d;
  logic [31:0]          cdb_wdata_q, cdb_wdata_d;
  logic [31:0]          cdb_jump_q, cdb_jump_d;

  logic                 alu_ready_c, lsb_ready_c;
  logic                 alu_push, lsb_push;
  logic                 alu_ne, lsb_ne;
  logic                 grant_alu, grant_lsb;
  alu_ent_t             alu_head;
  lsb_ent_t             lsb_head;

  assign alu_ready_c = (alu_cnt_q < 2'd2) & ~clear;
  assign lsb_ready_c = (lsb_cnt_q < 2'd2) & ~clear;

  // Ready already includes ~clear, so a push never coincides with a flush.
  assign alu_push = bus.alu_valid & alu_ready_c;
  assign lsb_push = bus.lsb_valid & lsb_ready_c;

  // Grant uses pre-push counts, so a freshly pushed entry is never bypassed.
  assign alu_ne    = (alu_cnt_q != 2'd0);
  assign lsb_ne    = (lsb_cnt_q != 2'd0);
  assign grant_alu = alu_ne & (~lsb_ne | last_grant_q);
  assign grant_lsb = lsb_ne & (~alu_ne | ~last_grant_q);

  assign alu_head = alu_mem_q[alu_rp_q];
  assign lsb_head = lsb_mem_q[lsb_rp_q];

  always_comb begin
    alu_wp_d     = alu_wp_q;
    alu_rp_d     = alu_rp_q;
    alu_cnt_d    = alu_cnt_q;
    lsb_wp_d     = lsb_wp_q;
    lsb_rp_d     = lsb_rp_q;
    lsb_cnt_d    = lsb_cnt_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_src_d    = cdb_src_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_op_d     = cdb_op_q;
    cdb_rd_d     = cdb_rd_q;
    cdb_wdata_d  = cdb_wdata_q;
    cdb_jump_d   = cdb_jump_q;

    if (rdy_in) begin
      if (clear) begin
        // Flush: offered results are discarded silently, err_drop survives.
        alu_wp_d     = 1'b0;
        alu_rp_d     = 1'b0;
        alu_cnt_d    = 2'd0;
        lsb_wp_d     = 1'b0;
        lsb_rp_d     = 1'b0;
        lsb_cnt_d    = 2'd0;
        last_grant_d = 1'b1;
        cdb_valid_d  = 1'b0;
      end else begin
        if ((bus.alu_valid & ~alu_ready_c) | (bus.lsb_valid & ~lsb_ready_c)) begin
          err_d = 1'b1;
        end

        if (alu_push) begin
          alu_wp_d = alu_wp_q + 1'b1;
        end
        if (lsb_push) begin
          lsb_wp_d = lsb_wp_q + 1'b1;
        end

        alu_cnt_d = alu_cnt_q + 2'(alu_push) - 2'(grant_alu);
        lsb_cnt_d = lsb_cnt_q + 2'(lsb_push) - 2'(grant_lsb);

        if (grant_alu) begin
          alu_rp_d     = alu_rp_q + 1'b1;
          last_grant_d = 1'b0;
          cdb_valid_d  = 1'b1;
          cdb_src_d    = 1'b0;
          cdb_tag_d    = alu_head.tag;
          cdb_op_d     = alu_head.op;
          cdb_rd_d     = alu_head.rd;
          cdb_wdata_d  = alu_head.wdata;
          cdb_jump_d   = alu_head.jump;
        end else if (grant_lsb) begin
          // Loads always complete as LOAD with no destination/redirect fields.
          lsb_rp_d     = lsb_rp_q + 1'b1;
          last_grant_d = 1'b1;
          cdb_valid_d  = 1'b1;
          cdb_src_d    = 1'b1;
          cdb_tag_d    = lsb_head.tag;
          cdb_op_d     = OP_LOAD;
          cdb_rd_d     = 5'd0;
          cdb_wdata_d  = lsb_head.wdata;
          cdb_jump_d   = 32'd0;
        end else begin
          cdb_valid_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      alu_wp_q     <= 1'b0;
      alu_rp_q     <= 1'b0;
      alu_cnt_q    <= 2'd0;
      lsb_wp_q     <= 1'b0;
      lsb_rp_q     <= 1'b0;
      lsb_cnt_q    <= 2'd0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      cdb_valid_q  <= 1'b0;
      cdb_src_q    <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_op_q     <= 3'd0;
      cdb_rd_q     <= 5'd0;
      cdb_wdata_q  <= 32'd0;
      cdb_jump_q   <= 32'd0;
    end else begin
      alu_wp_q     <= alu_wp_d;
      alu_rp_q     <= alu_rp_d;
      alu_cnt_q    <= alu_cnt_d;
      lsb_wp_q     <= lsb_wp_d;
      lsb_rp_q     <= lsb_rp_d;
      lsb_cnt_q    <= lsb_cnt_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_src_q    <= cdb_src_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_op_q     <= cdb_op_d;
      cdb_rd_q     <= cdb_rd_d;
      cdb_wdata_q  <= cdb_wdata_d;
      cdb_jump_q   <= cdb_jump_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && alu_push) begin
      alu_mem_q[alu_wp_q] <= '{tag: bus.alu_tag, op: bus.alu_op, rd: bus.alu_rd,
                               wdata: bus.alu_wdata, jump: bus.alu_jump};
    end
    if (!rst_in && rdy_in && lsb_push) begin
      lsb_mem_q[lsb_wp_q] <= '{tag: bus.lsb_tag, wdata: bus.lsb_wdata};
    end
  end

  assign bus.alu_ready = alu_ready_c;
  assign bus.lsb_ready = lsb_ready_c;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_op    = cdb_op_q;
  assign bus.cdb_rd    = cdb_rd_q;
  assign bus.cdb_wdata = cdb_wdata_q;
  assign bus.cdb_jump  = cdb_jump_q;
  assign bus.err_drop  = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized bench for cdb_arbiter against a queue-based reference model
module tb_cdb_arbiter;
  localparam int RW = 4;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear;

  cdb_arbiter_if #(.ROB_WIDTH(RW)) bus ();

  cdb_arbiter #(.ROB_WIDTH(RW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [RW-1:0] tag;
    logic [2:0]    op;
    logic [4:0]    rd;
    logic [31:0]   wdata;
    logic [31:0]   jump;
  } res_t;

  // Reference model: each source is a bounded queue of completed results,
  // already in the form they should take on the cdb.
  res_t alu_q[$];
  res_t lsb_q[$];
  res_t m_cdb;
  logic m_valid, m_src, m_err, m_last, m_fields;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int a_n, l_n;
    res_t e;
    if (rst_in) begin
      alu_q.delete();
      lsb_q.delete();
      m_valid = 1'b0; m_src = 1'b0; m_cdb = '0; m_last = 1'b1; m_err = 1'b0;
      m_fields = 1'b1;
    end else if (rdy_in) begin
      m_fields = 1'b0;
      if (clear) begin
        alu_q.delete();
        lsb_q.delete();
        m_valid = 1'b0;
        m_last  = 1'b1;
      end else begin
        a_n = alu_q.size();
        l_n = lsb_q.size();
        if ((bus.alu_valid && a_n == 2) || (bus.lsb_valid && l_n == 2)) m_err = 1'b1;
        if (a_n > 0 && (l_n == 0 || m_last)) begin
          m_cdb = alu_q.pop_front(); m_src = 1'b0; m_valid = 1'b1; m_last = 1'b0; m_fields = 1'b1;
        end else if (l_n > 0) begin
          m_cdb = lsb_q.pop_front(); m_src = 1'b1; m_valid = 1'b1; m_last = 1'b1; m_fields = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
        if (bus.alu_valid && a_n < 2) begin
          e = '{tag: bus.alu_tag, op: bus.alu_op, rd: bus.alu_rd, wdata: bus.alu_wdata, jump: bus.alu_jump};
          alu_q.push_back(e);
        end
        if (bus.lsb_valid && l_n < 2) begin
          e = '{tag: bus.lsb_tag, op: 3'd3, rd: 5'd0, wdata: bus.lsb_wdata, jump: 32'd0};
          lsb_q.push_back(e);
        end
      end
    end else begin
      m_fields = 1'b0;
    end
  endtask

  initial begin
    int phase;
    int pa, pl;
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_tag = '0; bus.alu_op = '0; bus.alu_rd = '0;
    bus.alu_wdata = '0; bus.alu_jump = '0;
    bus.lsb_valid = 1'b0; bus.lsb_tag = '0; bus.lsb_wdata = '0;
    m_valid = 1'b0; m_src = 1'b0; m_cdb = '0; m_last = 1'b1; m_err = 1'b0; m_fields = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_in);
      phase = (cyc / 200) % 5;
      case (phase)
        0: begin pa = 30;  pl = 30;  end
        1: begin pa = 100; pl = 100; end
        2: begin pa = 90;  pl = 50;  end
        3: begin pa = 60;  pl = 60;  end
        default: begin pa = 15; pl = 80; end
      endcase
      rst_in = (cyc < 2) || ($urandom_range(0, 249) == 0);
      rdy_in = ($urandom_range(0, 7) != 0);
      clear  = ($urandom_range(0, 39) == 0);
      bus.alu_valid = ($urandom_range(1, 100) <= pa);
      bus.alu_tag   = RW'($urandom);
      bus.alu_op    = 3'($urandom_range(0, 5));
      bus.alu_rd    = 5'($urandom);
      bus.alu_wdata = $urandom;
      bus.alu_jump  = $urandom;
      bus.lsb_valid = ($urandom_range(1, 100) <= pl);
      bus.lsb_tag   = RW'($urandom);
      bus.lsb_wdata = $urandom;
      #1;
      chk("alu_ready", 64'(bus.alu_ready), 64'((alu_q.size() < 2) && !clear));
      chk("lsb_ready", 64'(bus.lsb_ready), 64'((lsb_q.size() < 2) && !clear));
      if (cyc >= 2) begin
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
        chk("err_drop",  64'(bus.err_drop),  64'(m_err));
        if (m_fields) begin
          chk("cdb_src",   64'(bus.cdb_src),   64'(m_src));
          chk("cdb_tag",   64'(bus.cdb_tag),   64'(m_cdb.tag));
          chk("cdb_op",    64'(bus.cdb_op),    64'(m_cdb.op));
          chk("cdb_rd",    64'(bus.cdb_rd),    64'(m_cdb.rd));
          chk("cdb_wdata", 64'(bus.cdb_wdata), 64'(m_cdb.wdata));
          chk("cdb_jump",  64'(bus.cdb_jump),  64'(m_cdb.jump));
        end
      end
      @(posedge clk_in);
      model_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
